// File: rtl/raizing_cen_bank.sv
// raizing_cen_bank
//   Multi-channel fractional clock-enable generator. Each channel has its own
//   N/M accumulator that produces a base strobe on N out of every M clocks.
//   A binary tap chain divides that base rate by 2^k. New ratios are only
//   adopted at a channel's wrap, or while the channel is idle (M=0), so
//   retargeting a running clock never produces a short or doubled period.
//
// Ports
//   CLK      in   1          system clock, all state on the rising edge
//   RESET_N  in   1          asynchronous active-low reset
//   PAUSE    in   1          (only with RAIZING_CEN_PAUSE_EN) freeze all channels
//   N_IN     in   NCH*RW     numerator,   channel c at [c*RW +: RW]
//   M_IN     in   NCH*RW     denominator, same packing; M=0 disables channel
//   CEN      out  NCH*DIVN   enable strobes, channel c tap k at c*DIVN+k
//   CENB     out  NCH*DIVN   half-phase strobes, same packing
//
// Optional feature macro: RAIZING_CEN_PAUSE_EN (adds PAUSE input).
module raizing_cen_bank #(
  parameter int NCH  = 4,
  parameter int RW   = 8,
  parameter int DIVN = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
`ifdef RAIZING_CEN_PAUSE_EN
  input  logic                 PAUSE,
`endif
  input  logic [NCH*RW-1:0]    N_IN,
  input  logic [NCH*RW-1:0]    M_IN,
  output logic [NCH*DIVN-1:0]  CEN,
  output logic [NCH*DIVN-1:0]  CENB
);

  // Tap counter needs DIVN-1 bits; keep at least one bit so DIVN=1 still elaborates.
  localparam int CW = (DIVN > 1) ? DIVN - 1 : 1;

  logic pause;
`ifdef RAIZING_CEN_PAUSE_EN
  assign pause = PAUSE;
`else
  assign pause = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [RW-1:0]   an_reg;
      logic [RW-1:0]   am_reg;
      logic [RW:0]     acc_reg;
      logic [CW-1:0]   cnt_reg;
      logic [DIVN-1:0] cen_reg;
      logic [DIVN-1:0] cenb_reg;

      logic [RW-1:0]   n_eff;
      logic [RW-1:0]   half;
      logic [RW:0]     sum;
      logic            active;
      logic            wrap;
      logic            h0;
      logic            load;
      logic [CW-1:0]   mk;
      logic [DIVN-1:0] cen_next;
      logic [DIVN-1:0] cenb_next;

      always_comb begin
        // N larger than M is clamped so the channel saturates at one strobe per clock.
        n_eff  = (an_reg < am_reg) ? an_reg : am_reg;
        half   = am_reg >> 1;
        sum    = acc_reg + {1'b0, n_eff};
        active = (am_reg != '0);
        wrap   = active && (sum >= {1'b0, am_reg});
        // Half strobe marks the accumulator crossing M/2 on a non-wrap edge.
        h0     = active && !wrap && (acc_reg < {1'b0, half}) && (sum >= {1'b0, half});
        // Idle channels listen continuously; running ones only at their wrap.
        load   = !active || wrap;

        mk           = '0;
        cen_next     = '0;
        cenb_next    = '0;
        cen_next[0]  = wrap;
        cenb_next[0] = h0;
        for (int k = 1; k < DIVN; k++) begin
          mk           = CW'((1 << k) - 1);
          // Tap k fires when the low k counter bits are all ones; its half
          // strobe fires halfway through that 2^k-pulse period.
          cen_next[k]  = wrap && ((cnt_reg & mk) == mk);
          cenb_next[k] = wrap && ((cnt_reg & mk) == (mk >> 1));
        end
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          an_reg   <= '0;
          am_reg   <= '0;
          acc_reg  <= '0;
          cnt_reg  <= '0;
          cen_reg  <= '0;
          cenb_reg <= '0;
        end else if (pause) begin
          // Phase is held; only the strobes are suppressed.
          cen_reg  <= '0;
          cenb_reg <= '0;
        end else begin
          cen_reg  <= cen_next;
          cenb_reg <= cenb_next;
          if (!active) begin
            acc_reg <= '0;
          end else if (wrap) begin
            acc_reg <= sum - {1'b0, am_reg};
          end else begin
            acc_reg <= sum;
          end
          if (load) begin
            an_reg <= N_IN[gi*RW +: RW];
            am_reg <= M_IN[gi*RW +: RW];
          end
          if (wrap) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign CEN[gi*DIVN +: DIVN]  = cen_reg;
      assign CENB[gi*DIVN +: DIVN] = cenb_reg;
    end
  endgenerate

endmodule

// File: tb/tb_raizing_cen_bank.sv
module tb_raizing_cen_bank;

  localparam int NCH  = 4;
  localparam int RW   = 8;
  localparam int DIVN = 4;
  localparam int NB   = NCH * DIVN;

  logic              clk;
  logic              rst_n;
  logic              pause;
  logic [NCH*RW-1:0] n_in;
  logic [NCH*RW-1:0] m_in;
  logic [NB-1:0]     cen;
  logic [NB-1:0]     cenb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected strobe times per output bit: CEN bits 0..NB-1, CENB bits NB..2*NB-1.
  int exp_q[2*NB][$];
  int pulse_cnt[2*NB];

  raizing_cen_bank #(.NCH(NCH), .RW(RW), .DIVN(DIVN)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
`ifdef RAIZING_CEN_PAUSE_EN
    .PAUSE   (pause),
`endif
    .N_IN    (n_in),
    .M_IN    (m_in),
    .CEN     (cen),
    .CENB    (cenb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == e at the negedge following rising edge number e.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic clear_sb();
    for (int b = 0; b < 2*NB; b++) begin
      exp_q[b].delete();
      pulse_cnt[b] = 0;
    end
  endtask

  task automatic set_ch(input int c, input int n, input int m);
    n_in[c*RW +: RW] = RW'(n);
    m_in[c*RW +: RW] = RW'(m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pause = 1'b0;
    n_in  = '0;
    m_in  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected strobes for the i-th base pulse (1-based since the tap counter was 0).
  task automatic push_p0(input int c, input int tm, input int i);
    exp_q[c*DIVN].push_back(tm);
    for (int k = 1; k < DIVN; k++) begin
      if (i % (1 << k) == 0)
        exp_q[c*DIVN + k].push_back(tm);
      if (i % (1 << k) == (1 << (k-1)))
        exp_q[NB + c*DIVN + k].push_back(tm);
    end
  endtask

  // Accumulator is zero at edge L with ratio n/m active; after t updates the
  // running total is n*t, so the phase before update t is n*(t-1) mod m.
  // Updates after tp are delayed by plen cycles (pause); tp<0 means no pause.
  task automatic plan(input int c, input int n, input int m, input int L,
                      input int count, input int i0, input int tp, input int plen,
                      output int i_end);
    int ne, ab, s, tm, i;
    ne = (n > m) ? m : n;
    i  = i0;
    if (ne > 0 && m > 0) begin
      for (int t = 1; t <= count; t++) begin
        ab = (ne * (t - 1)) % m;
        s  = ab + ne;
        tm = L + t + ((tp >= 0 && t > tp) ? plen : 0);
        if (s >= m) begin
          i = i + 1;
          push_p0(c, tm, i);
        end else if (ab < m/2 && s >= m/2) begin
          exp_q[NB + c*DIVN].push_back(tm);
        end
      end
    end
    i_end = i;
  endtask

  // Pops whatever the scoreboard expects this cycle and compares every strobe bit.
  task automatic observe(input int ncyc);
    logic [2*NB-1:0] expv, act;
    repeat (ncyc) begin
      @(negedge clk);
      expv = '0;
      for (int b = 0; b < 2*NB; b++) begin
        if (exp_q[b].size() > 0 && exp_q[b][0] == cyc) begin
          expv[b] = 1'b1;
          void'(exp_q[b].pop_front());
        end
      end
      act = {cenb, cen};
      for (int b = 0; b < 2*NB; b++)
        if (act[b] === 1'b1) pulse_cnt[b]++;
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL strobes cyc=%0d got=%h want=%h", cyc, act, expv);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pause = 1'b0;
    n_in  = '0;
    m_in  = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({cenb, cen} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {cenb, cen});
    end
    rst_n = 1'b1;
    clear_sb();
    observe(20);
    $display("test_reset: idle after reset checked through cyc=%0d", cyc);
  endtask

  task automatic test_ch0_taps();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(0, 1, 7);
    L = cyc + 1;
    plan(0, 1, 7, L, 120, 0, -1, 0, ie);
    observe(121);
    $display("test_ch0_taps: N=1 M=7 load edge %0d, %0d base pulses planned", L, ie);
  endtask

  task automatic test_ch1_frac();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(1, 8, 189);
    L = cyc + 1;
    plan(1, 8, 189, L, 400, 0, -1, 0, ie);
    observe(190);
    total++;
    if (pulse_cnt[DIVN] != 8) begin
      bad++;
      $display("FAIL ch1_cen0_count got=%0d want=8", pulse_cnt[DIVN]);
    end
    total++;
    if (pulse_cnt[DIVN+1] != 4) begin
      bad++;
      $display("FAIL ch1_cen1_count got=%0d want=4", pulse_cnt[DIVN+1]);
    end
    observe(211);
    $display("test_ch1_frac: N=8 M=189 window counts cen0=%0d cen1=%0d",
             pulse_cnt[DIVN], pulse_cnt[DIVN+1]);
  endtask

  task automatic test_ch2_retarget();
    int L, i1, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(2, 1, 7);
    L = cyc + 1;
    plan(2, 1, 7, L, 7, 0, -1, 0, i1);
    observe(4);
    // acc is 3 here; the new ratio must wait for the wrap at edge L+7.
    set_ch(2, 2, 7);
    plan(2, 2, 7, L + 7, 60, i1, -1, 0, ie);
    observe(64);
    $display("test_ch2_retarget: change at cyc=%0d, new ratio from edge %0d", L + 3, L + 7);
  endtask

  task automatic test_ch3_enable();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(3, 0, 0);
    observe(10);
    set_ch(3, 5, 5);
    L = cyc + 1;
    plan(3, 5, 5, L, 40, 0, -1, 0, ie);
    observe(41);
    total++;
    if (pulse_cnt[3*DIVN] != 40) begin
      bad++;
      $display("FAIL ch3_every_cycle got=%0d want=40", pulse_cnt[3*DIVN]);
    end
    $display("test_ch3_enable: N=M=5 load edge %0d, cen0 pulses=%0d", L, pulse_cnt[3*DIVN]);
  endtask

  task automatic test_clamp_and_zero();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(0, 9, 4);
    L = cyc + 1;
    plan(0, 9, 4, L, 30, 0, -1, 0, ie);
    observe(31);
    $display("test_clamp: N=9 M=4 pulses=%0d", pulse_cnt[0]);
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(0, 0, 4);
    observe(100);
    total++;
    if (pulse_cnt[0] != 0) begin
      bad++;
      $display("FAIL n_zero_quiet got=%0d want=0", pulse_cnt[0]);
    end
    $display("test_zero: N=0 M=4 pulses=%0d", pulse_cnt[0]);
  endtask

  task automatic test_async_reset();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(0, 1, 7);
    L = cyc + 1;
    plan(0, 1, 7, L, 7, 0, -1, 0, ie);
    observe(8);
    // CEN[0] is high right now; reset between edges must clear it at once.
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({cenb, cen} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {cenb, cen});
    end
    clear_sb();
    @(negedge clk);
    rst_n = 1'b1;
    L = cyc + 1;
    plan(0, 1, 7, L, 60, 0, -1, 0, ie);
    observe(61);
    $display("test_async_reset: restart load edge %0d", L);
  endtask

`ifdef RAIZING_CEN_PAUSE_EN
  task automatic test_pause();
    int L, ie;
    do_reset();
    clear_sb();
    @(negedge clk);
    set_ch(0, 1, 7);
    L = cyc + 1;
    plan(0, 1, 7, L, 120, 0, 10, 50, ie);
    observe(11);
    pause = 1'b1;
    observe(50);
    pause = 1'b0;
    observe(110);
    $display("test_pause: paused edges %0d..%0d", L + 11, L + 60);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pause = 1'b0;
    n_in  = '0;
    m_in  = '0;
    test_reset();
    test_ch0_taps();
    test_ch1_frac();
    test_ch2_retarget();
    test_ch3_enable();
    test_clamp_and_zero();
    test_async_reset();
`ifdef RAIZING_CEN_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
